// File: rtl/skew_feeder_if.sv
// Bundle of control, matrix inputs and skewed feed outputs for skew_feeder.
// The master drives the request side and the slave (the feeder) drives the feed lanes.
interface skew_feeder_if #(
  parameter int W = 32,
  parameter int N = 3
);
  logic             i_en;
  logic             i_start;
  logic             i_mode;
  logic [W*N*N-1:0] i_A;
  logic [W*N*N-1:0] i_B;
  logic [W*N-1:0]   o_A_in;
  logic [W*N-1:0]   o_B_in;
  logic             o_valid;
  logic             o_sync;
  logic             o_mode;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_en, i_start, i_mode, i_A, i_B,
    input  o_A_in, o_B_in, o_valid, o_sync, o_mode, o_busy, o_done
  );

  modport slave (
    input  i_en, i_start, i_mode, i_A, i_B,
    output o_A_in, o_B_in, o_valid, o_sync, o_mode, o_busy, o_done
  );
endinterface

// File: rtl/skew_feeder.sv
// Feeds a captured A/B matrix pair into a systolic array as diagonally skewed
// row/column lanes, then drains and pulses done.
module skew_feeder #(
  parameter int W     = 32,
  parameter int N     = 3,
  parameter int DRAIN = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  skew_feeder_if.slave  bus
);
  localparam int TW        = $clog2(2*N-1+DRAIN) + 1;
  localparam int FEED_LAST = 2*N - 2;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [TW-1:0]    t_reg, t_next;
  logic [W*N*N-1:0] a_cap_reg, a_cap_next;
  logic [W*N*N-1:0] b_cap_reg, b_cap_next;
  logic             mode_reg, mode_next;
  logic [W*N-1:0]   a_in_reg, b_in_reg;
  logic [W*N-1:0]   a_feed, b_feed;
  logic             feed_next;

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    a_cap_next = a_cap_reg;
    b_cap_next = b_cap_reg;
    mode_next  = mode_reg;
    if (bus.i_en) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.i_start) begin
            a_cap_next = bus.i_A;
            b_cap_next = bus.i_B;
            mode_next  = bus.i_mode;
            t_next     = '0;
            state_next = S_FEED;
          end
        end
        S_FEED: begin
          if (t_reg == TW'(FEED_LAST)) begin
            t_next     = '0;
            state_next = S_DRAIN;
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
        S_DRAIN: begin
          if (t_reg == TW'(DRAIN-1)) begin
            t_next     = '0;
            state_next = S_DONE;
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Lanes are computed for the step being entered, from the capture mux, so the
  // first FEED cycle already shows data captured on the same edge.
  assign feed_next = (state_next == S_FEED);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [TW-1:0] k;
    logic          in_win;
    assign k      = t_next - TW'(gi);
    assign in_win = feed_next && (t_next >= TW'(gi)) && (k < TW'(N));
    assign a_feed[gi*W +: W] = in_win ? a_cap_next[(gi*N + int'(k))*W +: W] : '0;
    assign b_feed[gi*W +: W] = in_win ? b_cap_next[(int'(k)*N + gi)*W +: W] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      t_reg     <= '0;
      a_cap_reg <= '0;
      b_cap_reg <= '0;
      mode_reg  <= 1'b0;
      a_in_reg  <= '0;
      b_in_reg  <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      a_cap_reg <= a_cap_next;
      b_cap_reg <= b_cap_next;
      mode_reg  <= mode_next;
      if (bus.i_en) begin
        a_in_reg <= a_feed;
        b_in_reg <= b_feed;
      end
    end
  end

  // sync and done decode held registers, so a stall stretches them without
  // creating a second enabled occurrence.
  assign bus.o_A_in  = a_in_reg;
  assign bus.o_B_in  = b_in_reg;
  assign bus.o_valid = (state_reg == S_FEED) && bus.i_en;
  assign bus.o_sync  = (state_reg == S_FEED) && (t_reg == '0);
  assign bus.o_busy  = (state_reg != S_IDLE);
  assign bus.o_done  = (state_reg == S_DONE);
  assign bus.o_mode  = mode_reg;
endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder (W=8, N=3, DRAIN=3): fixed vector table,
// directed corner sequences and random traffic against an operation-level model.
module tb_skew_feeder;
  localparam int W = 8;
  localparam int N = 3;
  localparam int D = 3;
  localparam int L = 2*N - 1 + D;

  logic i_clk;
  logic i_rst_n;
  int   errors = 0;
  int   checks = 0;

  skew_feeder_if #(.W(W), .N(N)) bus ();

  skew_feeder #(.W(W), .N(N), .DRAIN(D)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: p = number of enabled cycles since capture (-1 when idle).
  int   p = -1;
  int   am [N][N];
  int   bm [N][N];
  logic mmode = 1'b0;
  int   ops = 0;

  typedef struct {
    logic        en;
    logic        st;
    logic        valid;
    logic        sync;
    logic        busy;
    logic        done;
    logic [23:0] a;
    logic [23:0] b;
  } vec_t;

  vec_t tbl [11];

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic en, input logic st, input logic md);
    if (en) begin
      if (p < 0) begin
        if (st) begin
          for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
              am[r][k] = int'(bus.i_A[(r*N+k)*W +: W]);
              bm[r][k] = int'(bus.i_B[(r*N+k)*W +: W]);
            end
          mmode = md;
          p = 0;
        end
      end else if (p == L) begin
        p = -1;
      end else begin
        p++;
      end
    end
  endtask

  task automatic check_model();
    logic [23:0] ea;
    logic [23:0] eb;
    logic [7:0]  v;
    ea = '0;
    eb = '0;
    if (p >= 0 && p <= 2*N-2) begin
      for (int r = 0; r < N; r++) begin
        int k;
        k = p - r;
        if (k >= 0 && k < N) begin
          v = am[r][k][7:0];
          ea[r*W +: W] = v;
          v = bm[k][r][7:0];
          eb[r*W +: W] = v;
        end
      end
    end
    chkb("m_valid", bus.o_valid, (p >= 0 && p <= 2*N-2) && bus.i_en);
    chkb("m_sync",  bus.o_sync,  p == 0);
    chkb("m_busy",  bus.o_busy,  p >= 0);
    chkb("m_done",  bus.o_done,  p == L);
    chkb("m_mode",  bus.o_mode,  mmode);
    chkw("m_a_in",  bus.o_A_in,  ea);
    chkw("m_b_in",  bus.o_B_in,  eb);
    if (p == L && bus.i_en) begin
      ops++;
      $display("op %0d complete mode=%0d t=%0t", ops, mmode, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic st, input logic md, input bit use_model);
    bus.i_en    = en;
    bus.i_start = st;
    bus.i_mode  = md;
    @(posedge i_clk);
    model_edge(en, st, md);
    @(negedge i_clk);
    if (use_model) check_model();
  endtask

  task automatic set_ab_seq();
    for (int i = 0; i < N*N; i++) begin
      bus.i_A[i*W +: W] = 8'(i + 1);
      bus.i_B[i*W +: W] = 8'(i + 10);
    end
  endtask

  task automatic rand_ab();
    for (int i = 0; i < N*N; i++) begin
      bus.i_A[i*W +: W] = 8'($urandom);
      bus.i_B[i*W +: W] = 8'($urandom);
    end
  endtask

  initial begin
    int n;
    int done_at;
    int run;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000001, 24'h00000a};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000402, 24'h000b0d};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h070503, 24'h0c0e10};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h080600, 24'h0f1100};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h090000, 24'h120000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 24'h000000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};

    i_rst_n     = 1'b0;
    bus.i_en    = 1'b0;
    bus.i_start = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    repeat (2) @(negedge i_clk);
    check_model();
    i_rst_n = 1'b1;

    // Vector table: full product with A=1..9, B=10..18, start offered during DONE.
    set_ab_seq();
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].en, tbl[i].st, 1'b0, 1'b0);
      chkb($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].valid);
      chkb($sformatf("tbl%0d_sync", i),  bus.o_sync,  tbl[i].sync);
      chkb($sformatf("tbl%0d_busy", i),  bus.o_busy,  tbl[i].busy);
      chkb($sformatf("tbl%0d_done", i),  bus.o_done,  tbl[i].done);
      chkw($sformatf("tbl%0d_a", i),     bus.o_A_in,  tbl[i].a);
      chkw($sformatf("tbl%0d_b", i),     bus.o_B_in,  tbl[i].b);
    end
    $display("table vectors applied: 11 rows");

    // Two-cycle stall at t=2.
    set_ab_seq();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 2; s++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chkw("stall_hold_a", bus.o_A_in, 24'h070503);
      chkb("stall_valid", bus.o_valid, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chkw("stall_resume_t3", bus.o_A_in, 24'h080600);
    n = 5;
    done_at = -1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      n++;
      if (bus.o_done && done_at < 0) done_at = n;
    end
    chkw("stall_done_latency", 24'(done_at), 24'd10);

    // Asynchronous reset at t=3, then a clean rerun.
    set_ab_seq();
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    chkw("rst_a_zero", bus.o_A_in, 24'h0);
    chkw("rst_b_zero", bus.o_B_in, 24'h0);
    chkb("rst_valid", bus.o_valid, 1'b0);
    chkb("rst_busy",  bus.o_busy,  1'b0);
    chkb("rst_mode",  bus.o_mode,  1'b0);
    p = -1;
    mmode = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      n++;
      if (bus.o_done && done_at < 0) done_at = n;
    end
    chkw("rerun_done_latency", 24'(done_at), 24'd8);

    // start held high with A/B churning every cycle.
    run = -1;
    for (int i = 0; i < 32; i++) begin
      rand_ab();
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      if (!bus.o_busy) begin
        if (run >= 0) run++;
      end else if (run > 0) begin
        chkw("busy_gap", 24'(run), 24'd1);
        run = 0;
      end else if (run < 0) begin
        run = 0;
      end
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Mode latched at capture only.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chkb("mode_held", bus.o_mode, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chkb("mode_recapture", bus.o_mode, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic with stalls.
    for (int i = 0; i < 400; i++) begin
      rand_ab();
      cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
